// File: rtl/prog_dumper.sv
// Program-memory readback: streams bytes 0..PROG_LEN over a valid/ready
// byte interface after load, optionally stopping at the first NUL byte.
module prog_dumper #(
    parameter int PROG_ADDR_WIDTH = 12,
    parameter int PROG_LEN        = 4095,
    parameter bit STOP_ON_NUL     = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dump_req,
    output logic                       prog_re,
    output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
    input  logic [7:0]                 prog_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [PROG_ADDR_WIDTH-1:0] LAST = PROG_ADDR_WIDTH'(PROG_LEN);

    state_t                     state, state_nxt;
    logic [PROG_ADDR_WIDTH-1:0] addr_nxt;
    logic [7:0]                 data_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            prog_addr <= '0;
            out_data  <= 8'h00;
        end else begin
            state     <= state_nxt;
            prog_addr <= addr_nxt;
            out_data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = prog_addr;
        data_nxt  = out_data;
        unique case (state)
            S_IDLE: begin
                if (dump_req) begin
                    state_nxt = S_READ;
                    addr_nxt  = '0;
                end
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: begin
                // synchronous RAM: prog_rd reflects the READ-cycle address here
                if (STOP_ON_NUL && prog_rd == 8'h00) begin
                    state_nxt = S_DONE;
                end else begin
                    data_nxt  = prog_rd;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (prog_addr == LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        addr_nxt  = prog_addr + 1'b1;
                        state_nxt = S_READ;
                    end
                end
            end
            S_DONE: begin
                if (!dump_req) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign prog_re   = (state == S_READ);
    assign out_valid = (state == S_SEND);
    assign busy      = (state == S_READ) || (state == S_WAIT) || (state == S_SEND);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_prog_dumper.sv
// Directed bench for prog_dumper: three instances cover the plain dump,
// STOP_ON_NUL early termination and the single-byte PROG_LEN=0 case.
module tb_prog_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // instance a: plain dump, PROG_LEN=3
    logic        req_a, rdy_a, re_a, vld_a, busy_a, done_a;
    logic [11:0] addr_a;
    logic [7:0]  rd_a, data_a;
    logic [7:0]  mem_a [4];

    // instance n: STOP_ON_NUL=1, PROG_LEN=3
    logic        req_n, rdy_n, re_n, vld_n, busy_n, done_n;
    logic [3:0]  addr_n;
    logic [7:0]  rd_n, data_n;
    logic [7:0]  mem_n [4];

    // instance z: PROG_LEN=0
    logic        req_z, rdy_z, re_z, vld_z, busy_z, done_z;
    logic [3:0]  addr_z;
    logic [7:0]  rd_z, data_z;

    prog_dumper #(.PROG_ADDR_WIDTH(12), .PROG_LEN(3), .STOP_ON_NUL(1'b0)) u_a (
        .clk(clk), .reset(reset), .dump_req(req_a), .prog_re(re_a),
        .prog_addr(addr_a), .prog_rd(rd_a), .out_valid(vld_a),
        .out_ready(rdy_a), .out_data(data_a), .busy(busy_a), .done(done_a)
    );

    prog_dumper #(.PROG_ADDR_WIDTH(4), .PROG_LEN(3), .STOP_ON_NUL(1'b1)) u_n (
        .clk(clk), .reset(reset), .dump_req(req_n), .prog_re(re_n),
        .prog_addr(addr_n), .prog_rd(rd_n), .out_valid(vld_n),
        .out_ready(rdy_n), .out_data(data_n), .busy(busy_n), .done(done_n)
    );

    prog_dumper #(.PROG_ADDR_WIDTH(4), .PROG_LEN(0), .STOP_ON_NUL(1'b0)) u_z (
        .clk(clk), .reset(reset), .dump_req(req_z), .prog_re(re_z),
        .prog_addr(addr_z), .prog_rd(rd_z), .out_valid(vld_z),
        .out_ready(rdy_z), .out_data(data_z), .busy(busy_z), .done(done_z)
    );

    // synchronous RAM models
    always @(posedge clk) begin
        if (re_a) rd_a <= (addr_a < 12'd4) ? mem_a[addr_a[1:0]] : 8'hEE;
        if (re_n) rd_n <= (addr_n < 4'd4) ? mem_n[addr_n[1:0]] : 8'hEE;
        if (re_z) rd_z <= (addr_z == 4'd0) ? 8'hA5 : 8'hEE;
    end

    // ready driver for instance a: fixed level or random with low stretches
    logic rnd_on = 1'b0;
    logic rdy_fix_a = 1'b1;
    int   lo_cnt = 0;
    always @(negedge clk) begin
        if (!rnd_on) begin
            rdy_a = rdy_fix_a;
        end else if (lo_cnt > 0) begin
            rdy_a = 1'b0;
            lo_cnt--;
        end else if ($urandom_range(0, 7) == 0) begin
            rdy_a  = 1'b0;
            lo_cnt = 9;
        end else begin
            rdy_a = 1'($urandom_range(0, 1));
        end
    end

    // monitors, sampled mid low phase
    logic [7:0] q_a[$], q_n[$], q_z[$];
    int hs_a[$], ra_a[$], ra_n[$];
    int n_re_z = 0;
    int rc_n = 0;
    int dc_a = 0, dc_n = 0;
    logic pd_done_a = 1'b0, pd_done_n = 1'b0;
    logic pv_a = 1'b0;
    logic [7:0] pdat_a = 8'h00;
    int stable_err = 0;

    always begin
        @(negedge clk);
        #2;
        if (vld_a && rdy_a) begin
            q_a.push_back(data_a);
            hs_a.push_back(cyc);
        end
        if (re_a) ra_a.push_back(int'(addr_a));
        if (pv_a && !(vld_a && data_a == pdat_a)) stable_err++;
        pv_a   = vld_a && !rdy_a;
        pdat_a = data_a;
        if (done_a && !pd_done_a) dc_a = cyc;
        pd_done_a = done_a;

        if (vld_n && rdy_n) q_n.push_back(data_n);
        if (re_n) begin
            ra_n.push_back(int'(addr_n));
            rc_n = cyc;
        end
        if (done_n && !pd_done_n) dc_n = cyc;
        pd_done_n = done_n;

        if (vld_z && rdy_z) q_z.push_back(data_z);
        if (re_z) n_re_z++;
    end

    task automatic wait_done(input int which, input string tag);
        logic d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #3;
            case (which)
                0:       d = done_a;
                1:       d = done_n;
                default: d = done_z;
            endcase
            if (d) return;
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int r, b, rb;

    initial begin
        mem_a[0] = 8'h41; mem_a[1] = 8'h42; mem_a[2] = 8'h43; mem_a[3] = 8'h44;
        mem_n[0] = 8'h2B; mem_n[1] = 8'h2E; mem_n[2] = 8'h00; mem_n[3] = 8'h5B;
        reset = 1'b1;
        req_a = 1'b0; req_n = 1'b0; req_z = 1'b0;
        rdy_n = 1'b1; rdy_z = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_re", 32'(re_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_valid", 32'(vld_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // plain dump, ready held high
        repeat (2) @(negedge clk);
        r = cyc;
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        wait_done(0, "d1");
        chk("d1_count", 32'(q_a.size()), 32'd4);
        chk("d1_bytes", {q_a[0], q_a[1], q_a[2], q_a[3]}, 32'h41424344);
        chk("d1_latency", 32'(hs_a[0] - r), 32'd3);
        chk("d1_gap01", 32'(hs_a[1] - hs_a[0]), 32'd3);
        chk("d1_gap12", 32'(hs_a[2] - hs_a[1]), 32'd3);
        chk("d1_gap23", 32'(hs_a[3] - hs_a[2]), 32'd3);
        chk("d1_done_lag", 32'(dc_a - hs_a[3]), 32'd1);
        chk("d1_re_count", 32'(ra_a.size()), 32'd4);
        chk("d1_re_addrs", {8'(ra_a[0]), 8'(ra_a[1]), 8'(ra_a[2]), 8'(ra_a[3])}, 32'h00010203);
        chk("d1_busy_end", 32'(busy_a), 32'd0);

        // random backpressure with dump_req held high through DONE
        @(negedge clk);
        #3;
        chk("idle_done", 32'(done_a), 32'd0);
        b = q_a.size();
        rb = ra_a.size();
        rnd_on = 1'b1;
        lo_cnt = 10;
        req_a = 1'b1;
        wait_done(0, "d2");
        chk("d2_count", 32'(q_a.size() - b), 32'd4);
        chk("d2_bytes", {q_a[b], q_a[b+1], q_a[b+2], q_a[b+3]}, 32'h41424344);
        chk("d2_stable", 32'(stable_err), 32'd0);
        repeat (20) @(negedge clk);
        #3;
        chk("hold_done", 32'(done_a), 32'd1);
        chk("hold_no_redump", 32'(ra_a.size() - rb), 32'd4);
        rnd_on = 1'b0;
        rdy_fix_a = 1'b1;
        req_a = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("drop_idle", 32'({busy_a, done_a}), 32'd0);

        // re-request repeats from address 0
        b = q_a.size();
        rb = ra_a.size();
        @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        wait_done(0, "d3");
        chk("d3_count", 32'(q_a.size() - b), 32'd4);
        chk("d3_bytes", {q_a[b], q_a[b+1], q_a[b+2], q_a[b+3]}, 32'h41424344);
        chk("d3_first_addr", 32'(ra_a[rb]), 32'd0);

        // STOP_ON_NUL
        @(negedge clk);
        req_n = 1'b1;
        @(negedge clk);
        req_n = 1'b0;
        wait_done(1, "nul");
        repeat (3) @(negedge clk);
        chk("nul_count", 32'(q_n.size()), 32'd2);
        chk("nul_bytes", {16'h0, q_n[0], q_n[1]}, 32'h00002B2E);
        chk("nul_re_count", 32'(ra_n.size()), 32'd3);
        chk("nul_last_addr", 32'(ra_n[ra_n.size()-1]), 32'd2);
        chk("nul_done_in_wait", 32'(dc_n - rc_n), 32'd2);

        // PROG_LEN=0
        @(negedge clk);
        req_z = 1'b1;
        @(negedge clk);
        req_z = 1'b0;
        wait_done(2, "len0");
        repeat (3) @(negedge clk);
        chk("len0_count", 32'(q_z.size()), 32'd1);
        chk("len0_byte", 32'(q_z[0]), 32'hA5);
        chk("len0_re_count", 32'(n_re_z), 32'd1);

        // async reset while a byte is stalled in SEND
        @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        for (int i = 0; i < 100 && addr_a != 12'd2; i++) begin
            @(negedge clk);
            #3;
        end
        rdy_fix_a = 1'b0;
        for (int i = 0; i < 100 && !vld_a; i++) begin
            @(negedge clk);
            #3;
        end
        chk("pre_rst_valid", 32'(vld_a), 32'd1);
        chk("pre_rst_data", 32'(data_a), 32'h43);
        b = q_a.size();
        rb = ra_a.size();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(vld_a), 32'd0);
        chk("async_addr", 32'(addr_a), 32'd0);
        chk("async_data", 32'(data_a), 32'd0);
        chk("async_busy_done", 32'({busy_a, done_a, re_a}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rdy_fix_a = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        chk("post_rst_bytes", 32'(q_a.size() - b), 32'd0);
        chk("post_rst_reads", 32'(ra_a.size() - rb), 32'd0);
        chk("post_rst_idle", 32'({vld_a, busy_a, done_a}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
